b01_stream_driver: RTL and testbench

Serial-stream source and result collector for the b01 serial-flow comparator. Accepts pairs of parallel operand words over a valid/ready handshake and shifts them LSB-first onto the `line1`/`line2` serial lines, one bit per clock. In parallel it samples the comparator's `outp`/`overflw` return lines, deserializes `outp` into a result word, and flags any `overflw` seen. It sits between a test/stimulus host and a b01 instance.

---
 rtl/b01_drv_pkg.sv | 20 ++
 rtl/b01_sipo.sv | 30 +++
 rtl/b01_stream_driver.sv | 107 ++++++++++
 tb/tb_b01_stream_driver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/b01_drv_pkg.sv
// Shared types and constants for the b01 serial-flow stream driver.
// Holds the controller state encoding and the bit/sample counter sizing rule.
package b01_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    HOLD
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LAT   = 1;

  // Counter must reach WIDTH+LAT, the index of the last capture edge.
  function automatic int cnt_width(input int width, input int lat);
    return $clog2(width + lat + 1);
  endfunction

endpackage

// File: rtl/b01_sipo.sv
// Capture register for the comparator return lines: deserializes outp LSB-first
// and accumulates any overflw seen during the word's capture window.
module b01_sipo #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample,
  input  logic             din,
  input  logic             ovf,
  output logic [WIDTH-1:0] result,
  output logic             ovf_seen
);

  // Shifting in at the MSB leaves the first sample at bit 0 after WIDTH samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result   <= '0;
      ovf_seen <= 1'b0;
    end else if (clear) begin
      result   <= '0;
      ovf_seen <= 1'b0;
    end else if (sample) begin
      result   <= {din, result[WIDTH-1:1]};
      ovf_seen <= ovf_seen | ovf;
    end
  end

endmodule

// File: rtl/b01_stream_driver.sv
// Serial-stream source and result collector for a b01 comparator: shifts operand
// pairs LSB-first onto line1/line2 and collects the returned outp/overflw stream.
module b01_stream_driver
  import b01_drv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = DEF_LAT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             line1,
  output logic             line2,
  input  logic             outp,
  input  logic             overflw,
  output logic [WIDTH-1:0] result,
  output logic             ovf_seen,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int            CW           = cnt_width(WIDTH, LAT);
  localparam logic [CW-1:0] LAST_BIT     = CW'(WIDTH);
  localparam logic [CW-1:0] FIRST_SAMPLE = CW'(LAT + 1);
  localparam logic [CW-1:0] LAST_SAMPLE  = CW'(WIDTH + LAT);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic             load, sample;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sample    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sample = (cnt >= FIRST_SAMPLE);
        if (cnt == LAST_BIT) state_nxt = DRAIN;
      end
      DRAIN: begin
        sample = (cnt >= FIRST_SAMPLE);
        if (cnt == LAST_SAMPLE) state_nxt = HOLD;
      end
      HOLD: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt equals k just before edge E(k); bit 0 goes out on the accepting edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      sh_a  <= '0;
      sh_b  <= '0;
      line1 <= 1'b0;
      line2 <= 1'b0;
    end else if (load) begin
      cnt   <= CW'(1);
      sh_a  <= op_a >> 1;
      sh_b  <= op_b >> 1;
      line1 <= op_a[0];
      line2 <= op_b[0];
    end else if (state == SHIFT || state == DRAIN) begin
      if (cnt != LAST_SAMPLE) cnt <= cnt + CW'(1);
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      line1 <= (state == SHIFT && cnt != LAST_BIT) ? sh_a[0] : 1'b0;
      line2 <= (state == SHIFT && cnt != LAST_BIT) ? sh_b[0] : 1'b0;
    end
  end

  assign in_ready  = (state == IDLE);
  assign res_valid = (state == HOLD);

  b01_sipo #(.WIDTH(WIDTH)) u_sipo (
    .clock    (clock),
    .reset    (reset),
    .clear    (load),
    .sample   (sample),
    .din      (outp),
    .ovf      (overflw),
    .result   (result),
    .ovf_seen (ovf_seen)
  );

endmodule

// File: tb/tb_b01_stream_driver.sv
// Self-checking bench for b01_stream_driver with a registered XOR loopback model
// standing in for the b01 comparator (LAT=1 and LAT=3 instances).
module tb_b01_stream_driver;

  localparam int W1 = 8;
  localparam int L1 = 1;
  localparam int L3 = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // LAT=1 instance
  logic [7:0] op_a, op_b, result;
  logic in_valid = 1'b0, res_ready = 1'b0, overflw = 1'b0;
  logic in_ready, line1, line2, outp, ovf_seen, res_valid;

  // LAT=3 instance
  logic [7:0] op_a3 = '0, op_b3 = '0, result3;
  logic in_valid3 = 1'b0, res_ready3 = 1'b0, overflw3 = 1'b0;
  logic in_ready3, line1_3, line2_3, outp3, ovf_seen3, res_valid3;

  b01_stream_driver #(.WIDTH(W1), .LAT(L1)) dut (
    .clock(clock), .reset(reset), .op_a(op_a), .op_b(op_b),
    .in_valid(in_valid), .in_ready(in_ready), .line1(line1), .line2(line2),
    .outp(outp), .overflw(overflw), .result(result), .ovf_seen(ovf_seen),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  b01_stream_driver #(.WIDTH(W1), .LAT(L3)) dut3 (
    .clock(clock), .reset(reset), .op_a(op_a3), .op_b(op_b3),
    .in_valid(in_valid3), .in_ready(in_ready3), .line1(line1_3), .line2(line2_3),
    .outp(outp3), .overflw(overflw3), .result(result3), .ovf_seen(ovf_seen3),
    .res_valid(res_valid3), .res_ready(res_ready3)
  );

  // Comparator loopback model: outp is the XOR of the lines delayed LAT stages.
  logic       pipe1;
  logic [2:0] pipe3;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe1 <= 1'b0;
      pipe3 <= '0;
    end else begin
      pipe1 <= line1 ^ line2;
      pipe3 <= {pipe3[1:0], line1_3 ^ line2_3};
    end
  end
  assign outp  = pipe1;
  assign outp3 = pipe3[2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e0_cyc = 0;
  logic [8:0] sb_q[$];
  logic [8:0] exp_v;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops the expected {ovf_seen, result} on each result handshake.
  always @(negedge clock) begin
    #1;
    if (!reset && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(res_valid), 0);
      end else begin
        exp_v = sb_q.pop_front();
        check("result", 32'(result), 32'(exp_v[7:0]));
        check("ovf_seen", 32'(ovf_seen), 32'(exp_v[8]));
      end
    end
  end

  // Drives one word from a negedge; returns at the negedge after E(W+L) in HOLD.
  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input int ovf_edge);
    int waits;
    op_a = a; op_b = b; in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 40) begin
      @(negedge clock);
      waits++;
      check("gap_lines", 32'({line1, line2}), 0);
    end
    check("accept_ready", 32'(in_ready), 1);
    sb_q.push_back({(ovf_edge >= 0), a ^ b});
    @(posedge clock);
    for (int k = 0; k <= W1 + L1; k++) begin
      @(negedge clock);
      if (k == 0) begin
        e0_cyc    = cyc;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        op_a      = 8'($urandom);
        op_b      = 8'($urandom);
        check("busy_ready", 32'(in_ready), 0);
      end
      if (k < W1) begin
        check("line1", 32'(line1), 32'(a[k]));
        check("line2", 32'(line2), 32'(b[k]));
      end else begin
        check("drain_lines", 32'({line1, line2}), 0);
      end
      overflw = (k + 1 == ovf_edge);
      check("res_valid_rise", 32'(res_valid), 32'(k == W1 + L1));
      if (k < W1 + L1) @(posedge clock);
    end
  endtask

  task automatic release_word();
    res_ready = 1'b1;
    @(negedge clock);
    check("released_valid", 32'(res_valid), 0);
    check("released_ready", 32'(in_ready), 1);
  endtask

  initial begin
    int prev;
    op_a = '0; op_b = '0;
    repeat (2) @(negedge clock);
    check("rst_lines", 32'({line1, line2}), 0);
    check("rst_result", 32'(result), 0);
    check("rst_ovf", 32'(ovf_seen), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_ready", 32'(in_ready), 1);
    reset = 1'b0;
    @(negedge clock);

    // Basic word, then overflow pulse at E5, then a clean word again.
    send_word(8'hA5, 8'h0F, -1);
    release_word();
    send_word(8'hA5, 8'h0F, 5);
    release_word();
    send_word(8'hA5, 8'h0F, -1);

    // Host stalls 5 cycles while a new pair is already offered.
    op_a = 8'h12; op_b = 8'h34; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("stall_valid", 32'(res_valid), 1);
      check("stall_result", 32'(result), 32'h0AA);
      check("stall_ready", 32'(in_ready), 0);
    end
    res_ready = 1'b1;
    @(negedge clock);
    check("post_hs_valid", 32'(res_valid), 0);
    check("post_hs_ready", 32'(in_ready), 1);
    send_word(8'h12, 8'h34, -1);
    release_word();

    // Reset in the middle of a word discards it.
    op_a = 8'hFF; op_b = 8'h00; in_valid = 1'b1;
    check("abort_ready", 32'(in_ready), 1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_lines", 32'({line1, line2}), 0);
    check("midrst_valid", 32'(res_valid), 0);
    check("midrst_ready", 32'(in_ready), 1);
    check("midrst_result", 32'(result), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (12) begin
      @(negedge clock);
      check("no_ghost_valid", 32'(res_valid), 0);
    end
    send_word(8'hFF, 8'h00, -1);
    release_word();

    // Back-to-back words at the minimum period.
    send_word(8'h3C, 8'hC3, -1);
    prev = e0_cyc;
    res_ready = 1'b1;
    send_word(8'h00, 8'h00, -1);
    check("word_period", e0_cyc - prev, W1 + L1 + 2);
    release_word();

    // LAT=3 instance with a 3-stage loopback.
    op_a3 = 8'h01; op_b3 = 8'h00; in_valid3 = 1'b1;
    check("l3_ready", 32'(in_ready3), 1);
    @(posedge clock);
    for (int k = 0; k <= W1 + L3; k++) begin
      @(negedge clock);
      in_valid3 = 1'b0;
      check("l3_line1", 32'(line1_3), 32'(k == 0));
      check("l3_valid", 32'(res_valid3), 32'(k == W1 + L3));
      if (k < W1 + L3) @(posedge clock);
    end
    check("l3_result", 32'(result3), 32'h01);
    check("l3_ovf", 32'(ovf_seen3), 0);
    res_ready3 = 1'b1;
    @(negedge clock);
    check("l3_released", 32'(res_valid3), 0);
    res_ready3 = 1'b0;

    repeat (3) @(negedge clock);
    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
